// File: rtl/s_axis_rq_arbiter.sv
// s_axis_rq_arbiter
// Round-robin, packet-atomic arbiter that merges N_REQ requester-request
// AXI-Stream ports into one stream for the RQ adapter. Read requests
// (header tdata[31:30] == 2'b00) consume a credit from a pool of MAX_RD
// outstanding reads; cpl_done returns one credit.
//
// Ports:
//   user_clk, user_reset            clock, async active-high reset
//   s_req_t{valid,ready,data,keep,last,user}  N_REQ packed slave streams
//   m_axis_rq_t{valid,ready,data,keep,last,user}  merged master stream
//   cpl_done        one read request fully completed (1-cycle pulse)
//   rd_outstanding  current outstanding read count
//   grant           one-hot owner while holding a packet, else zero
//   credit_err      sticky: cpl_done seen with no reads outstanding
module s_axis_rq_arbiter #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32,
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned MAX_RD     = 32
) (
    input  logic                         user_clk,
    input  logic                         user_reset,
    input  logic [N_REQ-1:0]             s_req_tvalid,
    output logic [N_REQ-1:0]             s_req_tready,
    input  logic [N_REQ*DATA_WIDTH-1:0]  s_req_tdata,
    input  logic [N_REQ*KEEP_WIDTH-1:0]  s_req_tkeep,
    input  logic [N_REQ-1:0]             s_req_tlast,
    input  logic [N_REQ*4-1:0]           s_req_tuser,
    output logic                         m_axis_rq_tvalid,
    input  logic                         m_axis_rq_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_rq_tkeep,
    output logic                         m_axis_rq_tlast,
    output logic [3:0]                   m_axis_rq_tuser,
    input  logic                         cpl_done,
    output logic [7:0]                   rd_outstanding,
    output logic [N_REQ-1:0]             grant,
    output logic                         credit_err
);

    localparam int unsigned OW = $clog2(N_REQ);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_owner_q, last_owner_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              credit_err_q, credit_err_d;
    logic              first_beat_q, first_beat_d;

    logic [N_REQ-1:0]  eligible;
    logic              pick_valid;
    logic [OW-1:0]     pick;
    logic              xfer;
    logic              rd_inc;

    // A port may compete if it has a beat and is either a write or a read
    // for which a credit is still free (registered count, so a credit freed
    // by cpl_done becomes usable one cycle later).
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            eligible[i] = s_req_tvalid[i] &&
                          ((s_req_tdata[i*DATA_WIDTH+30 +: 2] != 2'b00) ||
                           (rd_cnt_q < 8'(MAX_RD)));
        end
    end

    // Round-robin search from last_owner+1. Scanning offsets from far to near
    // lets the nearest eligible port overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (eligible[i] &&
                    ((int'(last_owner_q) + k == i) ||
                     (int'(last_owner_q) + k == i + int'(N_REQ)))) begin
                    pick_valid = 1'b1;
                    pick       = OW'(i);
                end
            end
        end
    end

    // Output mux: only the owner is connected, and only while holding.
    always_comb begin
        m_axis_rq_tvalid = 1'b0;
        m_axis_rq_tdata  = '0;
        m_axis_rq_tkeep  = '0;
        m_axis_rq_tlast  = 1'b0;
        m_axis_rq_tuser  = '0;
        s_req_tready     = '0;
        grant            = '0;
        if (state_q == StHold) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (owner_q == OW'(i)) begin
                    m_axis_rq_tvalid = s_req_tvalid[i];
                    m_axis_rq_tdata  = s_req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_rq_tkeep  = s_req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                    m_axis_rq_tlast  = s_req_tlast[i];
                    m_axis_rq_tuser  = s_req_tuser[i*4 +: 4];
                    s_req_tready[i]  = m_axis_rq_tready;
                    grant[i]         = 1'b1;
                end
            end
        end
    end

    assign xfer   = (state_q == StHold) && m_axis_rq_tvalid && m_axis_rq_tready;
    assign rd_inc = xfer && first_beat_q && (m_axis_rq_tdata[31:30] == 2'b00);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        first_beat_d = first_beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d      = pick;
                    first_beat_d = 1'b1;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (xfer) begin
                    // Next beat is a header only after this packet ends.
                    first_beat_d = m_axis_rq_tlast;
                    if (m_axis_rq_tlast) begin
                        last_owner_d = owner_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit counter; eligibility keeps it at or below MAX_RD.
    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        credit_err_d = credit_err_q;
        if (rd_inc && !cpl_done) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
        end else if (!rd_inc && cpl_done) begin
            if (rd_cnt_q == 8'd0) begin
                credit_err_d = 1'b1;
            end else begin
                rd_cnt_d = rd_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= OW'(N_REQ - 1);
            rd_cnt_q     <= 8'd0;
            credit_err_q <= 1'b0;
            first_beat_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rd_cnt_q     <= rd_cnt_d;
            credit_err_q <= credit_err_d;
            first_beat_q <= first_beat_d;
        end
    end

    assign rd_outstanding = rd_cnt_q;
    assign credit_err     = credit_err_q;

endmodule

// File: tb/tb_s_axis_rq_arbiter.sv
// Directed bench for s_axis_rq_arbiter (2 ports, MAX_RD = 2). Each port is
// driven by a small packet sequencer; inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_s_axis_rq_arbiter;

    localparam int DW = 256;
    localparam int KW = 8;

    logic            clk;
    logic            user_reset;
    logic [1:0]      vl, ls;
    logic [DW-1:0]   d  [2];
    logic [KW-1:0]   kp [2];
    logic [3:0]      us [2];
    logic [1:0]      s_req_tready;
    logic            m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [3:0]      m_tuser;
    logic            cpl_done;
    logic [7:0]      rd_out;
    logic [1:0]      grant;
    logic            credit_err;

    s_axis_rq_arbiter #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .N_REQ      (2),
        .MAX_RD     (2)
    ) dut (
        .user_clk         (clk),
        .user_reset       (user_reset),
        .s_req_tvalid     (vl),
        .s_req_tready     (s_req_tready),
        .s_req_tdata      ({d[1], d[0]}),
        .s_req_tkeep      ({kp[1], kp[0]}),
        .s_req_tlast      (ls),
        .s_req_tuser      ({us[1], us[0]}),
        .m_axis_rq_tvalid (m_tvalid),
        .m_axis_rq_tready (m_tready),
        .m_axis_rq_tdata  (m_tdata),
        .m_axis_rq_tkeep  (m_tkeep),
        .m_axis_rq_tlast  (m_tlast),
        .m_axis_rq_tuser  (m_tuser),
        .cpl_done         (cpl_done),
        .rd_outstanding   (rd_out),
        .grant            (grant),
        .credit_err       (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-port sequencer state.
    int   left [2];
    int   len  [2];
    int   beat [2];
    int   pnum [2];
    bit   is_rd [2];
    logic [1:0] fire;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat encoding: [31:30] type, [15:8] packet number, [7:4] port, [3:0] beat.
    task automatic drive_ports();
        for (int i = 0; i < 2; i++) begin
            logic [DW-1:0] w;
            w        = '0;
            w[31:30] = is_rd[i] ? 2'b00 : 2'b01;
            w[15:8]  = 8'(pnum[i]);
            w[7:4]   = 4'(i);
            w[3:0]   = 4'(beat[i]);
            d[i]     = w;
            kp[i]    = 8'hFF >> beat[i];
            us[i]    = 4'(beat[i]) ^ 4'(i);
            vl[i]    = left[i] > 0;
            ls[i]    = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic setup_port(input int i, input int n_pkts, input int plen, input bit rd);
        left[i]  = n_pkts;
        len[i]   = plen;
        beat[i]  = 0;
        pnum[i]  = 0;
        is_rd[i] = rd;
    endtask

    task automatic settle();
        drive_ports();
        #1;
    endtask

    task automatic advance();
        fire = vl & s_req_tready;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    left[i]--;
                    pnum[i]++;
                end
            end
        end
    endtask

    logic [1:0] exp_ga [17] = '{0,1,1,1,0,2,2,2,0,1,1,1,0,2,2,2,0};
    logic [7:0] exp_ba [17] = '{8'h00,8'h00,8'h01,8'h02,8'h00,8'h10,8'h11,8'h12,8'h00,
                                8'h00,8'h01,8'h02,8'h00,8'h10,8'h11,8'h12,8'h00};
    logic [1:0] exp_gb [14] = '{0,1,0,2,0,1,0,2,0,0,0,0,1,0};
    logic [7:0] exp_rb [14] = '{0,0,1,1,1,1,2,2,2,2,2,1,1,2};
    logic [7:0] exp_kd [4]  = '{8'hFF,8'h7F,8'h3F,8'h1F};

    initial begin
        int n;
        user_reset = 1'b1;
        m_tready   = 1'b1;
        cpl_done   = 1'b0;
        for (int i = 0; i < 2; i++) setup_port(i, 0, 1, 1'b0);
        settle();
        @(negedge clk);
        #1;
        check_eq("rst grant", 64'(grant), 64'd0);
        check_eq("rst tready", 64'(s_req_tready), 64'd0);
        check_eq("rst m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst rd_out", 64'(rd_out), 64'd0);
        check_eq("rst credit_err", 64'(credit_err), 64'd0);
        @(negedge clk);
        user_reset = 1'b0;

        // A: two ports with continuous 3-beat writes -> alternating, atomic packets.
        setup_port(0, 2, 3, 1'b0);
        setup_port(1, 2, 3, 1'b0);
        for (int c = 0; c < 17; c++) begin
            settle();
            check_eq($sformatf("A grant c%0d", c), 64'(grant), 64'(exp_ga[c]));
            check_eq($sformatf("A tready c%0d", c), 64'(s_req_tready), 64'(exp_ga[c]));
            if (exp_ga[c] != 2'd0) begin
                check_eq($sformatf("A data c%0d", c), 64'(m_tdata[7:0]), 64'(exp_ba[c]));
                check_eq($sformatf("A last c%0d", c), 64'(m_tlast), 64'(exp_ba[c][3:0] == 4'd2));
            end
            advance();
        end

        // B: credit limit 2; port 0 issues 3 reads, port 1 two writes.
        setup_port(0, 3, 1, 1'b1);
        setup_port(1, 2, 1, 1'b0);
        for (int c = 0; c < 14; c++) begin
            cpl_done = (c == 10);
            settle();
            check_eq($sformatf("B grant c%0d", c), 64'(grant), 64'(exp_gb[c]));
            check_eq($sformatf("B rd_out c%0d", c), 64'(rd_out), 64'(exp_rb[c]));
            advance();
        end
        cpl_done = 1'b0;

        // C: increment and decrement together, then underflow.
        setup_port(0, 1, 1, 1'b1);
        setup_port(1, 0, 1, 1'b0);
        cpl_done = 1'b1;
        settle();
        check_eq("C grant blocked", 64'(grant), 64'd0);
        advance();
        cpl_done = 1'b0;
        settle();
        check_eq("C rd_out after cpl", 64'(rd_out), 64'd1);
        advance();
        cpl_done = 1'b1;
        settle();
        check_eq("C grant read", 64'(grant), 64'd1);
        advance();
        settle();
        check_eq("C rd_out inc+dec", 64'(rd_out), 64'd1);
        advance();
        settle();
        check_eq("C rd_out zero", 64'(rd_out), 64'd0);
        check_eq("C err before", 64'(credit_err), 64'd0);
        advance();
        cpl_done = 1'b0;
        settle();
        check_eq("C rd_out stays 0", 64'(rd_out), 64'd0);
        check_eq("C err set", 64'(credit_err), 64'd1);
        advance();

        // D: 4-beat write under 1,0,1,0 backpressure.
        setup_port(0, 1, 4, 1'b0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            m_tready = (c % 2 == 1);
            settle();
            if (m_tvalid && m_tready) begin
                if (n < 4) begin
                    check_eq($sformatf("D data b%0d", n), 64'(m_tdata[7:0]), 64'(n));
                    check_eq($sformatf("D keep b%0d", n), 64'(m_tkeep), 64'(exp_kd[n]));
                    check_eq($sformatf("D user b%0d", n), 64'(m_tuser), 64'(n));
                    check_eq($sformatf("D last b%0d", n), 64'(m_tlast), 64'(n == 3));
                end
                n++;
            end else if (grant == 2'b01) begin
                check_eq($sformatf("D stalled tready c%0d", c), 64'(s_req_tready), 64'd0);
            end
            advance();
        end
        check_eq("D beat count", 64'(n), 64'd4);
        m_tready = 1'b1;

        // E: reset on beat 2 of a 4-beat read, then port 0 must win again.
        setup_port(0, 1, 4, 1'b1);
        setup_port(1, 0, 1, 1'b0);
        settle();
        advance();
        settle();
        advance();
        settle();
        check_eq("E rd_out before rst", 64'(rd_out), 64'd1);
        advance();
        settle();
        check_eq("E beat2 offered", 64'(m_tdata[7:0]), 64'h02);
        user_reset = 1'b1;
        #1;
        check_eq("E async grant", 64'(grant), 64'd0);
        check_eq("E async m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("E async tready", 64'(s_req_tready), 64'd0);
        check_eq("E async rd_out", 64'(rd_out), 64'd0);
        check_eq("E async err", 64'(credit_err), 64'd0);
        @(negedge clk);
        user_reset = 1'b0;
        setup_port(0, 1, 4, 1'b1);
        setup_port(1, 1, 1, 1'b0);
        settle();
        check_eq("E post grant idle", 64'(grant), 64'd0);
        advance();
        settle();
        check_eq("E post grant p0", 64'(grant), 64'd1);
        check_eq("E post data", 64'(m_tdata[7:0]), 64'h00);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

endmodule

// File: doc/s_axis_rq_arbiter.md
S_AXIS_RQ_ARBITER -- requirements
Module: s_axis_rq_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256: width of the requester-request AXI-Stream data in bits.
REQ-002 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/32: dword-granular keep width.
REQ-003 The block SHALL have parameter N_REQ, default 2, legal range 2..4: number of requester ports.
REQ-004 The block SHALL have parameter MAX_RD, default 32, legal range 1..255: maximum outstanding read requests.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset: user_clk input 1 (sole clock, rising edge) and user_reset input 1 (asynchronous, active-high).
REQ-006 The block SHALL have s_req_tvalid, input, N_REQ bits: per-port beat valid.
REQ-007 The block SHALL have s_req_tready, output, N_REQ bits: per-port beat ready.
REQ-008 The block SHALL have s_req_tdata, input, N_REQ*DATA_WIDTH bits: port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have s_req_tkeep, input, N_REQ*KEEP_WIDTH bits: per-port dword keep.
REQ-010 The block SHALL have s_req_tlast, input, N_REQ bits: per-port end of packet.
REQ-011 The block SHALL have s_req_tuser, input, N_REQ*4 bits: per-port sideband (discontinue/poison/ECRC).
REQ-012 The block SHALL have the output stream m_axis_rq_tvalid, tready, tdata, tkeep, tlast and tuser: output, input, output, output, output and output respectively; widths 1, 1, DATA_WIDTH, KEEP_WIDTH, 1 and 4; this stream feeds the RQ adapter.
REQ-013 The block SHALL have cpl_done, input, 1 bit: single-cycle pulse, one read request fully completed.
REQ-014 The block SHALL have rd_outstanding, output, 8 bits: current outstanding read count.
REQ-015 The block SHALL have grant, output, N_REQ bits: one-hot owner while in HOLD, else zero.
REQ-016 The block SHALL have credit_err, output, 1 bit: sticky flag, cpl_done received with rd_outstanding == 0.

Function
REQ-017 The state machine SHALL have exactly two states, IDLE and HOLD.
REQ-018 A port SHALL be eligible in IDLE when s_req_tvalid[i]=1 and (its head beat is a write, i.e. tdata[31:30] != 2'b00, or rd_outstanding < MAX_RD).
REQ-019 In IDLE, when any port is eligible, the block SHALL select the first eligible port searching round-robin from last_owner+1 (mod N_REQ), register it as owner, and move to HOLD on the next edge.
REQ-020 In IDLE, the block SHALL hold all s_req_tready at 0 and m_axis_rq_tvalid at 0; one bubble cycle per packet is required behaviour.
REQ-021 In HOLD, the block SHALL drive the m_axis_rq_* data, keep, last, user and valid combinationally from the owner port, and s_req_tready[owner] = m_axis_rq_tready; all other readies SHALL be 0.
REQ-022 In HOLD, on m_axis_rq_tvalid & m_axis_rq_tready & m_axis_rq_tlast the block SHALL return to IDLE and set last_owner = owner.
REQ-023 A packet SHALL never be interleaved or preempted; the grant is held across any number of tvalid gaps from the owner.
REQ-024 The first accepted beat of a granted packet that is a read (tdata[31:30]==2'b00) SHALL increment rd_outstanding by 1 on that edge; a first-beat flag SHALL track the header beat and clear after the first transfer.
REQ-025 cpl_done SHALL decrement rd_outstanding by 1; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-026 cpl_done with rd_outstanding == 0 and no simultaneous increment SHALL leave the count at 0 and set credit_err.
REQ-027 rd_outstanding SHALL never exceed MAX_RD; the eligibility rule guarantees this without saturation logic.
REQ-028 A port blocked on read credit SHALL be skipped and SHALL NOT stall other eligible ports.
REQ-029 Eligibility SHALL be re-evaluated every IDLE cycle; a read port becomes eligible in the same cycle that cpl_done frees a credit only from the next cycle (registered count).

Reset
REQ-030 While user_reset is high, the block SHALL hold state = IDLE, grant = 0, s_req_tready = 0, m_axis_rq_tvalid = 0, rd_outstanding = 0, credit_err = 0, first-beat flag = 1, and last_owner = N_REQ-1 (so port 0 wins first).
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately with no completing tlast.
REQ-032 After reset, the block SHALL resume arbitration on the first edge after user_reset deasserts.

Verification
REQ-033 Ports 0 and 1 both present 3-beat writes continuously -> grant alternates 01,10,01,...; each packet is contiguous; one idle cycle between packets.
REQ-034 Port 1 is mid-packet and port 0 raises tvalid -> port 0's ready stays 0 until port 1's tlast beat is accepted; port 0 is granted after the bubble.
REQ-035 MAX_RD=2; port 0 issues 3 single-beat reads while port 1 has a write pending -> 2 reads pass, rd_outstanding=2, port 1's write is granted, and the third read waits until one cpl_done pulse, then passes and rd_outstanding returns to 2.
REQ-036 A read header is accepted in the same cycle as a cpl_done pulse with rd_outstanding=1 -> rd_outstanding remains 1; a cpl_done at 0 -> credit_err=1 and the count stays 0.
REQ-037 Backpressure: m_axis_rq_tready toggles 1,0,1,0 during a 4-beat packet -> every beat is delivered exactly once in order, with tkeep and tuser matched per beat.
REQ-038 user_reset is asserted on beat 2 of a 4-beat packet -> outputs take reset values asynchronously, rd_outstanding=0, and port 0 wins the next arbitration.
